// File: rtl/serial_adder_core_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package tt_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Carry-in seeded into the chain for A - B = A + ~B + 1.
    localparam logic SUB_CIN = 1'b1;

    // Digit counter width: clog2(n), never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_core_if.sv
// Operand/result handshake bundle for serial_adder_core.
interface serial_adder_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    // Producer/consumer side (operand loader and result driver).
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );

    // Core side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );
endinterface

// File: rtl/serial_adder_core_full_adder_slice.sv
// One-bit full adder: the half-adder slice extended with a carry input.
module full_adder_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_core.sv
// Digit-serial WIDTH-bit adder/subtractor. DIGIT bits per cycle ripple
// through a chain of full_adder_slice; the inter-digit carry lives in a flop.
module serial_adder_core
    import tt_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_core_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = count_width(N);

    if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_adder_core: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   chain_c;
    logic [DIGIT-1:0] chain_s;
    logic [WIDTH-1:0] sum_shift;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        full_adder_slice u_fa (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (chain_c[i]),
            .s    (chain_s[i]),
            .cout (chain_c[i+1])
        );
    end

    // New digit enters at the top; after N digits the LSB digit sits at bit 0.
    assign sum_shift = (sum_q >> DIGIT) | (WIDTH'(chain_s) << (WIDTH - DIGIT));

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        count_d = count_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? SUB_CIN : 1'b0;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain_c[DIGIT];
                if (count_q == CW'(N - 1)) begin
                    // The top slice of the last digit is the MSB.
                    cout_d  = chain_c[DIGIT];
                    ovf_d   = chain_c[DIGIT-1] ^ chain_c[DIGIT];
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_adder_core.sv
// Bench for serial_adder_core: DIGIT=1 and DIGIT=4 instances, WIDTH=8,
// checked against an arithmetic reference model.
module tb_serial_adder_core;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic in_valid, sub, out_ready;
    logic [7:0] a, b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_core_if #(.WIDTH(8)) bus1 ();
    serial_adder_core_if #(.WIDTH(8)) bus4 ();

    assign bus1.in_valid  = in_valid & ~sel;
    assign bus4.in_valid  = in_valid & sel;
    assign bus1.a         = a;
    assign bus4.a         = a;
    assign bus1.b         = b;
    assign bus4.b         = b;
    assign bus1.sub       = sub;
    assign bus4.sub       = sub;
    assign bus1.out_ready = out_ready;
    assign bus4.out_ready = out_ready;

    serial_adder_core #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_adder_core #(.WIDTH(8), .DIGIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic       in_ready_m, out_valid_m, busy_m, cout_m, ovf_m;
    logic [7:0] sum_m;

    always_comb begin
        in_ready_m  = sel ? bus4.in_ready  : bus1.in_ready;
        out_valid_m = sel ? bus4.out_valid : bus1.out_valid;
        busy_m      = sel ? bus4.busy      : bus1.busy;
        cout_m      = sel ? bus4.carry_out : bus1.carry_out;
        ovf_m       = sel ? bus4.overflow  : bus1.overflow;
        sum_m       = sel ? bus4.sum       : bus1.sum;
    end

    function automatic int lat_exp();
        return sel ? 2 : 8;
    endfunction

    // Plain two's-complement arithmetic view of the operation.
    function automatic res_t ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rsub);
        res_t r;
        logic [8:0] full;
        logic sb;
        if (!rsub) begin
            full = {1'b0, ra} + {1'b0, rb};
            r.s  = full[7:0];
            r.c  = full[8];
            sb   = rb[7];
        end else begin
            r.s = ra - rb;
            r.c = (ra >= rb);
            sb  = ~rb[7];
        end
        r.v = (ra[7] == sb) && (r.s[7] != ra[7]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] oa, input logic [7:0] ob, input logic os);
        a = oa;
        b = ob;
        sub = os;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid_m && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready_m, out_valid_m, busy_m, sum_m, cout_m, ovf_m} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset sel=%0d: got rdy=%b vld=%b busy=%b sum=%h c=%b v=%b, want 1 0 0 00 0 0",
                     sel, in_ready_m, out_valid_m, busy_m, sum_m, cout_m, ovf_m);
        end
    endtask

    task automatic test_directed();
        logic [7:0] da [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
        logic [7:0] db [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
        logic       ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] es [5] = '{8'h10, 8'h00, 8'h80, 8'hFE, 8'h7F};
        logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready_m !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_ready sel=%0d #%0d: got %b want 1", sel, i, in_ready_m);
            end
            start_op(da[i], db[i], ds[i]);
            wait_done(cyc);
            vectors++;
            if (cyc != lat_exp()) begin
                miscompares++;
                $display("FAIL directed_latency sel=%0d #%0d: got %0d want %0d", sel, i, cyc, lat_exp());
            end
            vectors++;
            if ({sum_m, cout_m, ovf_m} !== {es[i], ec[i], ev[i]}) begin
                miscompares++;
                $display("FAIL directed_result sel=%0d #%0d: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                         sel, i, sum_m, cout_m, ovf_m, es[i], ec[i], ev[i]);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        res_t e;
        int cyc;
        logic [7:0] ra, rb;
        logic rs;
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            e  = ref_model(ra, rb, rs);
            start_op(ra, rb, rs);
            wait_done(cyc);
            vectors++;
            if (cyc != lat_exp() || {sum_m, cout_m, ovf_m} !== {e.s, e.c, e.v}) begin
                miscompares++;
                $display("FAIL random sel=%0d a=%h b=%h sub=%b: got sum=%h c=%b v=%b lat=%0d want sum=%h c=%b v=%b lat=%0d",
                         sel, ra, rb, rs, sum_m, cout_m, ovf_m, cyc, e.s, e.c, e.v, lat_exp());
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        int cyc;
        e = ref_model(8'hA5, 8'h3C, 1'b0);
        start_op(8'hA5, 8'h3C, 1'b0);
        wait_done(cyc);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({out_valid_m, sum_m, cout_m, ovf_m} !== {1'b1, e.s, e.c, e.v}) begin
                miscompares++;
                $display("FAIL backpressure_hold sel=%0d cyc=%0d: got vld=%b sum=%h c=%b v=%b want 1 %h %b %b",
                         sel, k, out_valid_m, sum_m, cout_m, ovf_m, e.s, e.c, e.v);
            end
            tick();
        end
        release_result();
        vectors++;
        if ({out_valid_m, in_ready_m, busy_m} !== 3'b010) begin
            miscompares++;
            $display("FAIL backpressure_release sel=%0d: got vld=%b rdy=%b busy=%b want 0 1 0",
                     sel, out_valid_m, in_ready_m, busy_m);
        end
    endtask

    task automatic test_ignored_input();
        res_t e;
        int cyc;
        e = ref_model(8'h39, 8'h5A, 1'b1);
        start_op(8'h39, 8'h5A, 1'b1);
        cyc = 0;
        while (!out_valid_m && cyc < 50) begin
            vectors++;
            if (in_ready_m !== 1'b0 || busy_m !== 1'b1) begin
                miscompares++;
                $display("FAIL ignored_ready sel=%0d cyc=%0d: got rdy=%b busy=%b want 0 1", sel, cyc, in_ready_m, busy_m);
            end
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            sub = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (cyc != lat_exp() || {sum_m, cout_m, ovf_m} !== {e.s, e.c, e.v}) begin
            miscompares++;
            $display("FAIL ignored_result sel=%0d: got sum=%h c=%b v=%b lat=%0d want %h %b %b lat=%0d",
                     sel, sum_m, cout_m, ovf_m, cyc, e.s, e.c, e.v, lat_exp());
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start_op(8'hC3, 8'h4E, 1'b0);
        repeat (sel ? 1 : 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready_m, out_valid_m, busy_m, sum_m, cout_m, ovf_m} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_run sel=%0d: got rdy=%b vld=%b busy=%b sum=%h c=%b v=%b want 1 0 0 00 0 0",
                     sel, in_ready_m, out_valid_m, busy_m, sum_m, cout_m, ovf_m);
        end
        start_op(8'h12, 8'h34, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc != lat_exp() || {sum_m, cout_m, ovf_m} !== {8'h46, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL after_reset_add sel=%0d: got sum=%h c=%b v=%b lat=%0d want 46 0 0 lat=%0d",
                     sel, sum_m, cout_m, ovf_m, cyc, lat_exp());
        end
        release_result();
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        in_valid = 1'b0;
        sub = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            test_reset();
            test_directed();
            test_random();
            test_backpressure();
            test_ignored_input();
            test_reset_mid_run();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
